// File: rtl/mem_block_engine_if.sv
// Core/memory-side bus of the block-transfer engine: request fields, status,
// core load/store path and the single data_mem port.
interface mem_block_engine_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          Start;
  logic          Mode;
  logic [AW-1:0] SrcAddr;
  logic [AW-1:0] DstAddr;
  logic [AW-1:0] Len;
  logic [DW-1:0] FillVal;
  logic          Busy;
  logic          Done;
  logic [AW-1:0] CoreAddr;
  logic          CoreWrEn;
  logic [DW-1:0] CoreDataIn;
  logic [DW-1:0] CoreDataOut;
  logic [AW-1:0] MemAddr;
  logic          MemWrEn;
  logic [DW-1:0] MemDataIn;
  logic [DW-1:0] MemDataOut;

  // master: core + data_mem side; slave: the engine
  modport master (
    output Start, Mode, SrcAddr, DstAddr, Len, FillVal,
    output CoreAddr, CoreWrEn, CoreDataIn, MemDataOut,
    input  Busy, Done, CoreDataOut, MemAddr, MemWrEn, MemDataIn
  );
  modport slave (
    input  Start, Mode, SrcAddr, DstAddr, Len, FillVal,
    input  CoreAddr, CoreWrEn, CoreDataIn, MemDataOut,
    output Busy, Done, CoreDataOut, MemAddr, MemWrEn, MemDataIn
  );
endinterface

// File: rtl/mem_block_engine.sv
// Block copy/fill engine that owns the data_mem port while busy and passes
// the core's load/store path straight through otherwise.
module mem_block_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic               CLK,
  input logic               Reset,
  mem_block_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = '0;

  state_t        state;
  logic [AW-1:0] src_ptr, dst_ptr, count;
  logic [DW-1:0] buf_q, fill_r;
  logic          mode_r, busy_r, done_r;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      buf_q   <= '0;
      fill_r  <= '0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          src_ptr <= bus.SrcAddr;
          dst_ptr <= bus.DstAddr;
          count   <= bus.Len;
          mode_r  <= bus.Mode;
          fill_r  <= bus.FillVal;
          if (bus.Len == ZERO) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            state  <= bus.Mode ? WRITE : READ;
            busy_r <= 1'b1;
          end
        end
        READ: begin
          buf_q   <= bus.MemDataOut;
          src_ptr <= src_ptr + ONE;
          state   <= WRITE;
        end
        WRITE: begin
          dst_ptr <= dst_ptr + ONE;
          count   <= count - ONE;
          if (count == ONE) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            state <= mode_r ? WRITE : READ;
          end
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Engine write is squashed by Reset so an abort never lands a stray byte.
  always_comb begin
    bus.MemAddr   = bus.CoreAddr;
    bus.MemWrEn   = bus.CoreWrEn;
    bus.MemDataIn = bus.CoreDataIn;
    case (state)
      READ: begin
        bus.MemAddr = src_ptr;
        bus.MemWrEn = 1'b0;
      end
      WRITE: begin
        bus.MemAddr   = dst_ptr;
        bus.MemWrEn   = ~Reset;
        bus.MemDataIn = mode_r ? fill_r : buf_q;
      end
      default: ;
    endcase
  end

  assign bus.Busy        = busy_r;
  assign bus.Done        = done_r;
  assign bus.CoreDataOut = bus.MemDataOut;
endmodule
